// File: rtl/req_burst_ctl_pkg.sv
// Shared types and defaults for the burst request front end and its arbiter.
// Holds the 1-hot controller FSM encoding and the arbiter state encodings.
package req_burst_ctl_pkg;

  localparam int DEPTH_DEF     = 4;
  localparam int LEN_W_DEF     = 4;
  localparam int MAX_BURST_DEF = 4;
  localparam int GAP_DEF       = 1;

  typedef enum logic [3:0] {
    S_IDLE    = 4'b0001,
    S_REQ     = 4'b0010,
    S_XFER    = 4'b0100,
    S_BACKOFF = 4'b1000
  } state_t;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'b00,
    ARB_GNT0 = 2'b01,
    ARB_GNT1 = 2'b10
  } arb_state_t;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/req_burst_ctl_if.sv
// Command/request bundle between an upstream client, req_burst_ctl and the arbiter.
// Handshake: a command transfers on a rising clock edge where cmd_valid && cmd_ready;
// cmd_len must be stable while cmd_valid is high; a beat is any cycle with req && gnt.
interface req_burst_ctl_if #(
  parameter int DEPTH = req_burst_ctl_pkg::DEPTH_DEF,
  parameter int LEN_W = req_burst_ctl_pkg::LEN_W_DEF
);
  logic                       cmd_valid;
  logic [LEN_W-1:0]           cmd_len;
  logic                       cmd_ready;
  logic                       req;
  logic                       gnt;
  logic                       beat;
  logic                       last;
  logic                       busy;
  logic [$clog2(DEPTH):0]     fifo_count;
  req_burst_ctl_pkg::state_t  dbg_state;

  modport slave (
    input  cmd_valid, cmd_len, gnt,
    output cmd_ready, req, beat, last, busy, fifo_count, dbg_state
  );

  modport master (
    output cmd_valid, cmd_len, gnt,
    input  cmd_ready, req, beat, last, busy, fifo_count, dbg_state
  );
endinterface

// File: rtl/req_burst_ctl_cmd_fifo.sv
// Synchronous command FIFO (DEPTH x WIDTH) with occupancy count and async reset.
// Push is ignored when full and pop when empty, so callers may gate loosely.
module req_burst_ctl_cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_data,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_data,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr;
  logic [AW-1:0]    r_rd;
  logic [CW-1:0]    r_count;
  logic             w_push;
  logic             w_pop;

  assign o_full  = (r_count == CW'(DEPTH));
  assign o_empty = (r_count == '0);
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;
  assign o_data  = r_mem[r_rd];
  assign o_count = r_count;

  always_ff @(posedge clock) begin
    if (w_push) r_mem[r_wr] <= i_data;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + 1'b1;
      if (w_pop)  r_rd <= r_rd + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end
endmodule

// File: rtl/req_burst_ctl.sv
// Per-client request front end: queues commands, requests the arbiter, caps tenures
// at MAX_BURST beats then backs off GAP cycles. Optional REQ_BURST_STATS_EN adds wait_max.
module req_burst_ctl
  import req_burst_ctl_pkg::*;
#(
  parameter int DEPTH     = DEPTH_DEF,
  parameter int LEN_W     = LEN_W_DEF,
  parameter int MAX_BURST = MAX_BURST_DEF,
  parameter int GAP       = GAP_DEF
) (
  input  logic           clock,
  input  logic           reset,
  req_burst_ctl_if.slave bus
`ifdef REQ_BURST_STATS_EN
  ,
  output logic [15:0]    wait_max
`endif
);
  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam int RW    = LEN_W + 1;
  localparam int GAP_W = (GAP > 1) ? $clog2(GAP) : 1;

  state_t           r_state;
  logic             r_req;
  logic [RW-1:0]    r_remain;
  logic [RW-1:0]    r_tenure;
  logic [GAP_W-1:0] r_gap;

  logic             w_push;
  logic             w_pop;
  logic             w_full;
  logic             w_empty;
  logic [LEN_W-1:0] w_head;
  logic [CNT_W-1:0] w_count;
  logic             w_beat;
  logic [RW-1:0]    w_remain_dec;
  logic [RW-1:0]    w_tenure_inc;
  logic             w_tenure_end;

  assign w_push       = bus.cmd_valid && !w_full;
  assign w_pop        = (r_state == S_IDLE) && !w_empty;
  assign w_beat       = r_req && bus.gnt;
  assign w_remain_dec = r_remain - 1'b1;
  assign w_tenure_inc = r_tenure + 1'b1;
  assign w_tenure_end = (w_remain_dec == '0) || (w_tenure_inc == RW'(MAX_BURST));

  req_burst_ctl_cmd_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (LEN_W)
  ) u_fifo (
    .clock   (clock),
    .reset   (reset),
    .i_push  (w_push),
    .i_data  (bus.cmd_len),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  // req is only ever high in REQ/XFER, so a gnt there is always a beat; the
  // arbiter's trailing gnt after req falls lands in BACKOFF and is ignored.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_req    <= 1'b0;
      r_remain <= '0;
      r_tenure <= '0;
      r_gap    <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (!w_empty) begin
            r_remain <= {1'b0, w_head} + RW'(1);
            r_tenure <= '0;
            r_req    <= 1'b1;
            r_state  <= S_REQ;
          end
        end
        S_REQ, S_XFER: begin
          if (bus.gnt) begin
            r_remain <= w_remain_dec;
            r_tenure <= w_tenure_inc;
            if (w_tenure_end) begin
              r_req   <= 1'b0;
              r_gap   <= '0;
              r_state <= S_BACKOFF;
            end else begin
              r_state <= S_XFER;
            end
          end else begin
            r_state <= S_REQ;
          end
        end
        S_BACKOFF: begin
          if (r_gap == GAP_W'(GAP - 1)) begin
            if (r_remain != '0) begin
              r_req    <= 1'b1;
              r_tenure <= '0;
              r_state  <= S_REQ;
            end else begin
              r_state  <= S_IDLE;
            end
          end else begin
            r_gap <= r_gap + 1'b1;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_req   <= 1'b0;
        end
      endcase
    end
  end

  assign bus.cmd_ready  = !w_full;
  assign bus.req        = r_req;
  assign bus.beat       = w_beat;
  assign bus.last       = w_beat && (r_remain == RW'(1));
  assign bus.busy       = (r_state != S_IDLE) || !w_empty;
  assign bus.fifo_count = w_count;
  assign bus.dbg_state  = r_state;

`ifdef REQ_BURST_STATS_EN
  logic [15:0] r_wait_cur;
  logic [15:0] r_wait_max;
  logic [15:0] w_wait_nxt;

  assign w_wait_nxt = sat_inc16(r_wait_cur);

  // Run length of REQ cycles without gnt; any other cycle restarts the run.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_wait_cur <= '0;
      r_wait_max <= '0;
    end else if ((r_state == S_REQ) && !bus.gnt) begin
      r_wait_cur <= w_wait_nxt;
      if (w_wait_nxt > r_wait_max) r_wait_max <= w_wait_nxt;
    end else begin
      r_wait_cur <= '0;
    end
  end

  assign wait_max = r_wait_max;
`endif
endmodule
